// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and conversion helpers
package bcd_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input logic [BCD_W-1:0] nibble);
        return nibble <= BCD_MAX;
    endfunction

    // Vectors are carried as 16 bits (4 digits max); ndig selects how many count.
    function automatic int unsigned bcd_to_bin(input logic [15:0] vec, input int ndig);
        int unsigned acc;
        int unsigned weight;
        acc = 0;
        weight = 1;
        for (int i = 0; i < 4; i++) begin
            if (i < ndig) begin
                acc = acc + 32'(vec[4*i +: 4]) * weight;
                weight = weight * 10;
            end
        end
        return acc;
    endfunction

    function automatic logic [15:0] bin_to_bcd(input int unsigned value);
        logic [15:0] r;
        int unsigned v;
        v = value;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_modn_counter_if.sv
// rtl/bcd_modn_counter_if.sv - control and status bundle of the BCD modulo-N counter
interface bcd_modn_counter_if #(
    parameter int NDIG = 2
);
    logic                load;
    logic                en;
    logic                up;
    logic [4*NDIG-1:0]   d;
    logic [4*NDIG-1:0]   q;
    logic                tc;
    logic                co;
    logic                load_err;

    modport master (
        output load, en, up, d,
        input  q, tc, co, load_err
    );

    modport slave (
        input  load, en, up, d,
        output q, tc, co, load_err
    );
endinterface

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - next-value logic for one BCD digit, counting up or down
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] cur,
    input  logic             ci,
    input  logic             up,
    output logic [BCD_W-1:0] nxt,
    output logic             co_up,
    output logic             co_dn
);

    assign co_up = ci & (cur == BCD_MAX);
    assign co_dn = ci & (cur == '0);

    always_comb begin
        nxt = cur;
        if (ci) begin
            if (up) begin
                nxt = (cur >= BCD_MAX) ? '0 : cur + 4'd1;
            end else begin
                nxt = (cur == '0) ? BCD_MAX : cur - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_modn_counter.sv
// rtl/bcd_modn_counter.sv - multi-digit BCD modulo-N up/down counter with validated load and cascade carry
module bcd_modn_counter
    import bcd_pkg::*;
#(
    parameter int NDIG    = 2,
    parameter int MODULUS = 60,
    parameter int WRAP    = 1
) (
    input  logic                  clk,
    input  logic                  clr_n,
    bcd_modn_counter_if.slave     bus
);

    localparam int          W         = BCD_W * NDIG;
    localparam int unsigned MOD_U     = MODULUS;
    localparam logic [15:0] TERM_FULL = bin_to_bcd(MOD_U - 1);
    localparam logic [W-1:0] TERM     = TERM_FULL[W-1:0];

    logic [W-1:0]    q_r;
    logic [W-1:0]    chain_nxt;
    logic [W-1:0]    nxt;
    logic            err_r;
    logic [NDIG:0]   ci;
    logic [NDIG-1:0] co_up;
    logic [NDIG-1:0] co_dn;

    // With ci[0] tied high, the down-borrow out of the top digit means q is all zeros.
    assign ci[0] = 1'b1;

    for (genvar g = 0; g < NDIG; g++) begin : g_digit
        bcd_digit u_digit (
            .cur   (q_r[g*BCD_W +: BCD_W]),
            .ci    (ci[g]),
            .up    (bus.up),
            .nxt   (chain_nxt[g*BCD_W +: BCD_W]),
            .co_up (co_up[g]),
            .co_dn (co_dn[g])
        );
        assign ci[g+1] = bus.up ? co_up[g] : co_dn[g];
    end

    logic at_top;
    logic tc;
    assign at_top = (q_r == TERM);
    assign tc     = bus.up ? at_top : ci[NDIG];

    logic [15:0]  d_ext;
    logic         d_nibbles_ok;
    logic         load_ok;

    always_comb begin
        d_ext = '0;
        d_ext[W-1:0] = bus.d;
        d_nibbles_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            d_nibbles_ok = d_nibbles_ok & bcd_valid(bus.d[i*BCD_W +: BCD_W]);
        end
    end

    assign load_ok = d_nibbles_ok && (bcd_to_bin(d_ext, NDIG) < MOD_U);

    // Terminal override sits over the ripple chain so q stays inside 0..MODULUS-1.
    always_comb begin
        nxt = q_r;
        if (bus.load) begin
            if (load_ok) begin
                nxt = bus.d;
            end
        end else if (bus.en) begin
            if (tc) begin
                if (WRAP != 0) begin
                    nxt = bus.up ? '0 : TERM;
                end
            end else begin
                nxt = chain_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q_r   <= '0;
            err_r <= 1'b0;
        end else begin
            q_r <= nxt;
            if (bus.load) begin
                err_r <= ~load_ok;
            end
        end
    end

    assign bus.q        = q_r;
    assign bus.tc       = tc;
    assign bus.co       = bus.en & tc;
    assign bus.load_err = err_r;

endmodule

// File: tb/tb_bcd_modn_counter.sv
// tb/tb_bcd_modn_counter.sv - directed self-checking bench for bcd_modn_counter
module tb_bcd_modn_counter;

    logic clk;
    logic clr_n;
    int   checks;
    int   errors;

    bcd_modn_counter_if #(.NDIG(2)) i60 ();
    bcd_modn_counter_if #(.NDIG(2)) i24 ();
    bcd_modn_counter_if #(.NDIG(2)) isat ();
    bcd_modn_counter_if #(.NDIG(2)) imin ();
    bcd_modn_counter_if #(.NDIG(2)) ihr ();

    bcd_modn_counter #(.NDIG(2), .MODULUS(60), .WRAP(1)) u60 (.clk(clk), .clr_n(clr_n), .bus(i60));
    bcd_modn_counter #(.NDIG(2), .MODULUS(24), .WRAP(1)) u24 (.clk(clk), .clr_n(clr_n), .bus(i24));
    bcd_modn_counter #(.NDIG(2), .MODULUS(60), .WRAP(0)) usat (.clk(clk), .clr_n(clr_n), .bus(isat));
    bcd_modn_counter #(.NDIG(2), .MODULUS(60), .WRAP(1)) umin (.clk(clk), .clr_n(clr_n), .bus(imin));
    bcd_modn_counter #(.NDIG(2), .MODULUS(24), .WRAP(1)) uhr (.clk(clk), .clr_n(clr_n), .bus(ihr));

    assign ihr.en = imin.co;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        int exp;
        checks = 0;
        errors = 0;
        clr_n = 1'b0;
        i60.load = 0;  i60.en = 0;  i60.up = 1;  i60.d = '0;
        i24.load = 0;  i24.en = 0;  i24.up = 1;  i24.d = '0;
        isat.load = 0; isat.en = 0; isat.up = 1; isat.d = '0;
        imin.load = 0; imin.en = 0; imin.up = 1; imin.d = '0;
        ihr.load = 0;  ihr.up = 1;  ihr.d = '0;
        tick();

        // reset state
        check("rst_q", i60.q, 8'h00);
        check("rst_err", i60.load_err, 1'b0);
        check("rst_tc_up", i60.tc, 1'b0);
        i60.up = 0; #1;
        check("rst_tc_dn", i60.tc, 1'b1);
        check("rst_co_dn_en0", i60.co, 1'b0);
        i60.up = 1;
        clr_n = 1'b1;

        // 1: count up 61 cycles with wrap
        i60.en = 1; #1;
        exp = 0;
        for (int k = 0; k < 61; k++) begin
            check("t1_co", i60.co, (exp == 59) ? 1'b1 : 1'b0);
            tick();
            exp = (exp + 1) % 60;
            check("t1_q", i60.q, to_bcd(exp));
        end
        check("t1_end", i60.q, 8'h01);

        // 2: count down from 00
        i60.en = 0; clr_n = 0; tick(); clr_n = 1;
        i60.up = 0; i60.en = 1; #1;
        check("t2_tc0", i60.tc, 1'b1);
        check("t2_co0", i60.co, 1'b1);
        tick();
        check("t2_59", i60.q, 8'h59);
        check("t2_co59", i60.co, 1'b0);
        tick();
        check("t2_58", i60.q, 8'h58);
        for (int k = 0; k < 8; k++) tick();
        check("t2_50", i60.q, 8'h50);
        tick();
        check("t2_49", i60.q, 8'h49);
        i60.en = 0;

        // 3: load validation, MODULUS=24
        i24.load = 1; i24.d = 8'h23; tick();
        check("t3_q23", i24.q, 8'h23);
        check("t3_err0", i24.load_err, 1'b0);
        check("t3_tc", i24.tc, 1'b1);
        i24.d = 8'h24; tick();
        check("t3_q_hold24", i24.q, 8'h23);
        check("t3_err24", i24.load_err, 1'b1);
        i24.d = 8'h1A; tick();
        check("t3_q_hold1A", i24.q, 8'h23);
        check("t3_err1A", i24.load_err, 1'b1);
        i24.d = 8'h07; tick();
        check("t3_q07", i24.q, 8'h07);
        check("t3_err07", i24.load_err, 1'b0);
        i24.d = 8'h99; tick();
        check("t3_err99", i24.load_err, 1'b1);
        i24.load = 0; i24.en = 1; tick();
        check("t3_cnt08", i24.q, 8'h08);
        check("t3_err_sticky", i24.load_err, 1'b1);
        i24.en = 0;

        // 4: saturate at terminal
        isat.load = 1; isat.d = 8'h58; tick();
        isat.load = 0; isat.en = 1; isat.up = 1; tick();
        check("t4_59a", isat.q, 8'h59);
        check("t4_co_a", isat.co, 1'b1);
        tick();
        check("t4_59b", isat.q, 8'h59);
        check("t4_co_b", isat.co, 1'b1);
        tick();
        check("t4_59c", isat.q, 8'h59);
        check("t4_co_c", isat.co, 1'b1);
        isat.up = 0; #1;
        check("t4_tc_dn", isat.tc, 1'b0);
        tick();
        check("t4_58", isat.q, 8'h58);
        isat.en = 0;
        clr_n = 0; tick(); clr_n = 1;
        isat.en = 1; isat.up = 0; tick();
        check("t4_hold0", isat.q, 8'h00);
        check("t4_co0", isat.co, 1'b1);
        isat.en = 0;

        // 5: priority of clear and load over count
        i60.up = 1; i60.en = 1; i60.load = 1; i60.d = 8'h30;
        clr_n = 0; tick();
        check("t5_clr", i60.q, 8'h00);
        check("t5_clr_err", i60.load_err, 1'b0);
        clr_n = 1; tick();
        check("t5_load30", i60.q, 8'h30);
        i60.d = 8'h60; tick();
        check("t5_bad_hold", i60.q, 8'h30);
        check("t5_bad_err", i60.load_err, 1'b1);
        i60.load = 0; i60.en = 0;

        // 6: cascade minutes -> hours
        imin.load = 1; imin.d = 8'h59; ihr.load = 1; ihr.d = 8'h23; tick();
        imin.load = 0; ihr.load = 0; imin.en = 1; #1;
        check("t6_co_min", imin.co, 1'b1);
        check("t6_co_hr", ihr.co, 1'b1);
        tick();
        check("t6_min00", imin.q, 8'h00);
        check("t6_hr00", ihr.q, 8'h00);
        tick(); tick();
        check("t6_min02", imin.q, 8'h02);
        check("t6_hr_hold", ihr.q, 8'h00);
        imin.en = 0;
        imin.load = 1; imin.d = 8'h59; ihr.load = 1; ihr.d = 8'h05; tick();
        imin.load = 0; ihr.load = 0; imin.en = 1; tick();
        check("t6_min_wrap", imin.q, 8'h00);
        check("t6_hr06", ihr.q, 8'h06);
        imin.en = 0;
        imin.load = 1; imin.d = 8'h45; ihr.load = 1; ihr.d = 8'h12; tick();
        imin.load = 0; ihr.load = 0; imin.en = 1;
        tick(); tick(); tick();
        check("t6_min48", imin.q, 8'h48);
        check("t6_hr12", ihr.q, 8'h12);
        clr_n = 0; tick();
        check("t6_clr_min", imin.q, 8'h00);
        check("t6_clr_hr", ihr.q, 8'h00);
        clr_n = 1; imin.en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
